// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Brief    : Shared defaults and requester ids for the register-file
//            writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

  localparam int c_addr_w_dflt = 5;
  localparam int c_data_w_dflt = 32;
  // Pending time never exceeds two cycles, so two bits order any two slots.
  localparam int c_age_w       = 2;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_slot.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_slot
// Brief    : Single-entry writeback holding slot (valid, addr, data, age).
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_slot
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_dflt,
  parameter int DATA_W = c_data_w_dflt
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_consume,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_data,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_data,
  output logic [c_age_w-1:0] o_age
);

  logic               r_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [c_age_w-1:0] r_age;

  // A load wins over a consume so a granted slot refills at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_age   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_age   <= '0;
    end else if (i_consume) begin
      r_valid <= 1'b0;
      r_age   <= '0;
    end else if (r_valid && (r_age != '1)) begin
      r_age   <= r_age + 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_age   = r_age;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Two-requester (ALU/load) register-file writeback arbiter with
//            one holding slot per requester. Define RF_WB_STATS_EN to build
//            the saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_dflt,
  parameter int DATA_W  = c_data_w_dflt,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [DATA_W-1:0]  req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [DATA_W-1:0]  req1_data,
  output logic               req1_ready,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_a3,
  output logic [DATA_W-1:0]  rf_wd3,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [1:0]         w_valid;
  logic [1:0]         w_load;
  logic [1:0]         w_gnt;
  logic [ADDR_W-1:0]  w_in_addr [2];
  logic [DATA_W-1:0]  w_in_data [2];
  logic [ADDR_W-1:0]  w_addr    [2];
  logic [DATA_W-1:0]  w_data    [2];
  logic [c_age_w-1:0] w_age     [2];

  logic               w_gnt_any;
  req_id_e            w_gnt_id;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_data;
  req_id_e            r_rr_ptr;

  assign w_in_addr[0] = req0_addr;
  assign w_in_addr[1] = req1_addr;
  assign w_in_data[0] = req0_data;
  assign w_in_data[1] = req1_data;
  assign w_load       = {req1_valid & req1_ready, req0_valid & req0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    rf_wb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load[gi]),
      .i_consume (w_gnt[gi]),
      .i_addr    (w_in_addr[gi]),
      .i_data    (w_in_data[gi]),
      .o_valid   (w_valid[gi]),
      .o_addr    (w_addr[gi]),
      .o_data    (w_data[gi]),
      .o_age     (w_age[gi])
    );
  end

  // Same-address writes must retire in arrival order; otherwise round-robin.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = REQ_ALU;
    if (&w_valid) begin
      w_gnt_any = 1'b1;
      if (w_addr[0] == w_addr[1]) begin
        w_gnt_id = (w_age[1] > w_age[0]) ? REQ_LOAD : REQ_ALU;
      end else begin
        w_gnt_id = r_rr_ptr;
      end
    end else if (w_valid[0]) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = REQ_ALU;
    end else if (w_valid[1]) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = REQ_LOAD;
    end
  end

  assign w_gnt      = {w_gnt_any & (w_gnt_id == REQ_LOAD),
                       w_gnt_any & (w_gnt_id == REQ_ALU)};
  assign w_gnt_addr = (w_gnt_id == REQ_LOAD) ? w_addr[1] : w_addr[0];
  assign w_gnt_data = (w_gnt_id == REQ_LOAD) ? w_data[1] : w_data[0];

  // Register 0 is hardwired; its writes are swallowed without a strobe.
  assign rf_we      = w_gnt_any & (w_gnt_addr != '0);
  assign rf_a3      = rf_we ? w_gnt_addr : '0;
  assign rf_wd3     = rf_we ? w_gnt_data : '0;

  assign req0_ready = ~w_valid[0] | w_gnt[0];
  assign req1_ready = ~w_valid[1] | w_gnt[1];
  assign busy       = |w_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= REQ_ALU;
    end else if (&w_valid) begin
      r_rr_ptr <= (w_gnt_id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    end
  end

`ifdef RF_WB_STATS_EN
  logic               w_stall;
  logic [STALL_W-1:0] r_stall_cnt;

  assign w_stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        busy;
  logic [15:0] stall_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  rf_wb_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [4:0] a, input logic [31:0] d);
    req0_valid = v; req0_addr = a; req0_data = d;
  endtask

  task automatic drv1(input logic v, input logic [4:0] a, input logic [31:0] d);
    req1_valid = v; req1_addr = a; req1_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, rf_we, we);
    chk({tag, ".a3"}, rf_a3, a);
    chk({tag, ".wd3"}, rf_wd3, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.rdy0", req0_ready, 1'b1);
    chk("rst.rdy1", req1_ready, 1'b1);
    chk("rst.stall", stall_cnt, 16'd0);

    // Single ALU write
    drv0(1'b1, 5'd3, 32'h11);
    step();
    drv0(1'b0, '0, '0);
    chk_wr("single", 1'b1, 5'd3, 32'h11);
    chk("single.busy", busy, 1'b1);
    step();
    chk("single.idle", busy, 1'b0);
    chk("single.we0", rf_we, 1'b0);

    // Simultaneous, different addresses, rr_ptr=0
    drv0(1'b1, 5'd5, 32'hA);
    drv1(1'b1, 5'd6, 32'hB);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk_wr("rr.first", 1'b1, 5'd5, 32'hA);
    chk("rr.rdy1lo", req1_ready, 1'b0);
    chk("rr.rdy0hi", req0_ready, 1'b1);
    step();
    chk_wr("rr.second", 1'b1, 5'd6, 32'hB);
    chk("rr.rdy1hi", req1_ready, 1'b1);
    step();
    chk("rr.idle", busy, 1'b0);

    // Same address, same edge, rr_ptr=1: slot0 counts as older
    drv0(1'b1, 5'd7, 32'h2A);
    drv1(1'b1, 5'd7, 32'h1B);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk_wr("tie.first", 1'b1, 5'd7, 32'h2A);
    step();
    chk_wr("tie.second", 1'b1, 5'd7, 32'h1B);
    step();
    chk("tie.idle", busy, 1'b0);

    // Slot1 holds {7,1} one edge before slot0 gets {7,2}
    drv0(1'b1, 5'd9, 32'h9);
    drv1(1'b1, 5'd8, 32'h8);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b1, 5'd7, 32'h1);
    chk_wr("age.w8", 1'b1, 5'd8, 32'h8);
    chk("age.rdy0lo", req0_ready, 1'b0);
    step();
    drv1(1'b0, '0, '0);
    drv0(1'b1, 5'd7, 32'h2);
    chk_wr("age.w9", 1'b1, 5'd9, 32'h9);
    step();
    drv0(1'b0, '0, '0);
    chk_wr("age.old", 1'b1, 5'd7, 32'h1);
    step();
    chk_wr("age.new", 1'b1, 5'd7, 32'h2);
    step();
    chk("age.idle", busy, 1'b0);

    // Write to register 0 is consumed silently
    drv0(1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("r0.rdy_pre", req0_ready, 1'b1);
    step();
    drv0(1'b0, '0, '0);
    chk_wr("r0.pend", 1'b0, 5'd0, 32'h0);
    chk("r0.busy", busy, 1'b1);
    chk("r0.rdy", req0_ready, 1'b1);
    step();
    chk("r0.we", rf_we, 1'b0);
    chk("r0.idle", busy, 1'b0);

    // Continuous contention: three blocked cycles, then reset with both slots full
    drv0(1'b1, 5'd10, 32'h10);
    drv1(1'b1, 5'd11, 32'h11);
    step();
    chk_wr("st.c1", 1'b1, 5'd10, 32'h10);
    step();
    chk_wr("st.c2", 1'b1, 5'd11, 32'h11);
    step();
    chk_wr("st.c3", 1'b1, 5'd10, 32'h10);
    step();
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk("st.busy", busy, 1'b1);
`ifdef RF_WB_STATS_EN
    chk("st.cnt", stall_cnt, 16'd3);
`else
    chk("st.cnt", stall_cnt, 16'd0);
`endif
    rst_n = 1'b0;
    drv0(1'b1, 5'd12, 32'hC);
    drv1(1'b1, 5'd13, 32'hD);
    step();
    rst_n = 1'b1;
    drv0(1'b0, '0, '0);
    drv1(1'b0, '0, '0);
    chk_wr("rst2", 1'b0, 5'd0, 32'h0);
    chk("rst2.busy", busy, 1'b0);
    chk("rst2.rdy0", req0_ready, 1'b1);
    chk("rst2.rdy1", req1_ready, 1'b1);
    chk("rst2.stall", stall_cnt, 16'd0);
    step();
    chk("rst2.we", rf_we, 1'b0);
    chk("rst2.idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
